// File: rtl/cp0_intr_ctrl.sv
// cp0_intr_ctrl: coprocessor-0 style exception and interrupt controller.
// It sits upstream of the IF stage. It decides when fetch is redirected to the
// exception base or back to EPC, and it flushes IF/ID when that happens.
//
// Ports:
//   clk, clrn          clock; synchronous active-high reset (1 = reset)
//   intr               external interrupt request, level
//   stall              ID load-use stall, so the ID instruction repeats
//   if_pc              PC of the instruction in IF; saved to EPC on a take
//   id_is_branch       ID holds a branch/jump, which defers events
//   id_syscall/unimpl  synchronous exception sources decoded in ID
//   id_eret, id_mtc0   eret and mtc0 decoded in ID
//   cp0_rd, cp0_wdata  cp0 register index and mtc0 write data
//   cp0_rdata          mfc0 read data, combinational, pre-edge value
//   selpc              to IF: 0 npc, 1 epc, 2 exception base
//   epc                EPC register to IF
//   cancel             flush IF/ID
//   inta               interrupt acknowledge
//   in_exc             FSM is in the exception state
module cp0_intr_ctrl #(
   parameter logic [31:0] STATUS_INIT = 32'h0000_000F,
   parameter logic [4:0]  REG_STATUS  = 5'd12,
   parameter logic [4:0]  REG_CAUSE   = 5'd13,
   parameter logic [4:0]  REG_EPC     = 5'd14
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        intr,
   input  logic        stall,
   input  logic [31:0] if_pc,
   input  logic        id_is_branch,
   input  logic        id_syscall,
   input  logic        id_unimpl,
   input  logic        id_eret,
   input  logic        id_mtc0,
   input  logic [4:0]  cp0_rd,
   input  logic [31:0] cp0_wdata,
   output logic [31:0] cp0_rdata,
   output logic [1:0]  selpc,
   output logic [31:0] epc,
   output logic        cancel,
   output logic        inta,
   output logic        in_exc
);

   typedef enum logic [0:0] {StNorm, StExc} state_e;

   state_e      state_q, state_d;
   // Only the implemented bits are stored; everything else reads as zero.
   logic [3:0]  status_q, status_d;
   logic [1:0]  code_q, code_d;
   logic [31:0] epc_q, epc_d;
   logic        pend_q, pend_d;

   logic ok, sync_take, int_take, take, eret_take, sys_hit, unimpl_hit;

   assign ok         = ~stall & ~id_is_branch & (state_q == StNorm);
   assign sys_hit    = id_syscall & status_q[2];
   assign unimpl_hit = id_unimpl & status_q[3];
   assign sync_take  = ok & status_q[0] & (sys_hit | unimpl_hit);
   assign int_take   = ok & status_q[0] & status_q[1] & (pend_q | intr) & ~sync_take;
   assign take       = sync_take | int_take;
   assign eret_take  = id_eret & ~stall & (state_q == StExc);

   always_comb begin
      state_d  = state_q;
      status_d = status_q;
      code_d   = code_q;
      epc_d    = epc_q;
      // A take clears pend even if intr is still high in that same cycle.
      pend_d   = int_take ? 1'b0 : (pend_q | intr);

      if (id_mtc0 && !stall) begin
         if (cp0_rd == REG_STATUS) begin
            status_d = cp0_wdata[3:0];
         end else if (cp0_rd == REG_CAUSE) begin
            code_d = cp0_wdata[3:2];
         end else if (cp0_rd == REG_EPC) begin
            epc_d = cp0_wdata;
         end
      end

      // A take overrides any mtc0 to the same registers in this cycle.
      if (take) begin
         epc_d       = if_pc;
         status_d[0] = 1'b0;
         state_d     = StExc;
         if (sync_take) begin
            code_d = sys_hit ? 2'b01 : 2'b10;
         end else begin
            code_d = 2'b00;
         end
      end else if (eret_take) begin
         status_d[0] = 1'b1;
         state_d     = StNorm;
      end
   end

   always_ff @(posedge clk) begin
      if (clrn) begin
         state_q  <= StNorm;
         status_q <= STATUS_INIT[3:0];
         code_q   <= 2'b00;
         epc_q    <= 32'h0;
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         status_q <= status_d;
         code_q   <= code_d;
         epc_q    <= epc_d;
         pend_q   <= pend_d;
      end
   end

   always_comb begin
      cp0_rdata = 32'h0;
      if (cp0_rd == REG_STATUS) begin
         cp0_rdata = {28'h0, status_q};
      end else if (cp0_rd == REG_CAUSE) begin
         cp0_rdata = {28'h0, code_q, 2'b00};
      end else if (cp0_rd == REG_EPC) begin
         cp0_rdata = epc_q;
      end
   end

   always_comb begin
      selpc = 2'd0;
      if (!clrn) begin
         if (take) begin
            selpc = 2'd2;
         end else if (eret_take) begin
            selpc = 2'd1;
         end
      end
   end

   assign cancel = ~clrn & (take | eret_take);
   assign inta   = ~clrn & int_take;
   assign in_exc = ~clrn & (state_q == StExc);
   assign epc    = clrn ? 32'h0 : epc_q;

endmodule
